rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
- Owns the single write port (we3/ra3/wd3) of the 12 x 24-bit register file.
- Shares that port between two writeback requesters, ALU and memory-load, using a valid/ready handshake and round-robin arbitration.
- Runs a clear sweep after reset or on request, writing zero to every register.
- Write-port outputs are registered; they drive the register file directly.

Parameters:
- DATA_W, 24, writeback data width.
- ADDR_W, 4, register address width.
- NUM_REGS, 12, number of implemented registers (legal addresses 0..NUM_REGS-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  1-cycle request to start a clear sweep.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU writeback data.
- mem_valid  in  1  memory-load writeback request.
- mem_ready  out  1  memory request accepted this cycle.
- mem_addr  in  ADDR_W  memory destination register.
- mem_data  in  DATA_W  memory writeback data.
- rf_we  out  1  register-file write enable (to we3).
- rf_wa  out  ADDR_W  register-file write address (to ra3).
- rf_wd  out  DATA_W  register-file write data (to wd3).
- busy  out  1  high while in CLEAR.
- err_addr  out  1  1-cycle pulse: an accepted request had an illegal address.

Behaviour:
- Reset values:
  - rf_we=0, rf_wa=0, rf_wd=0, err_addr=0, alu_ready=0, mem_ready=0.
  - state=CLEAR, sweep counter=0, prio=ALU, so busy=1.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle, issue a write of 0 to address = counter, then increment the counter.
  - After issuing NUM_REGS-1, go to RUN and reset the counter to 0.
  - alu_ready and mem_ready are held at 0.
  - clr_req is ignored; the sweep is not restarted.
- Clear sweep timing: for k = 1..NUM_REGS cycles after rst deasserts, rf_we=1, rf_wa=k-1, rf_wd=0.
- RUN, clr_req=1: enter CLEAR next cycle. No transfer is accepted in the cycle clr_req is high, because readies are forced to 0.
- Ready equations (RUN, clr_req=0; combinational from valids and prio):
  - alu_ready = !mem_valid || prio==ALU
  - mem_ready = !alu_valid || prio==MEM
  - At most one transfer occurs per cycle.
- Transfer = valid && ready.
  - The next cycle shows rf_we=1, rf_wa=addr, rf_wd=data. Latency is 1 cycle.
  - With no transfer, rf_we=0; rf_wa and rf_wd hold their last values.
- Round-robin:
  - After an ALU transfer, prio=MEM.
  - After a MEM transfer, prio=ALU.
  - With no transfer, prio holds.
  - Sustained dual requests therefore alternate ALU, MEM, ALU, ...
- Illegal address (addr >= NUM_REGS):
  - The transfer is still accepted and prio still flips.
  - The next cycle shows rf_we=0 and err_addr=1 for one cycle.
  - rf_wa and rf_wd are not updated.
- Same address from both requesters: no merging; both are written in grant order, and the later write wins.
- Requesters must hold addr and data stable while valid=1 and ready=0. The block does not check this.
- rst mid-sweep or mid-transfer: next cycle shows reset values, and the sweep restarts from address 0. Any accepted-but-not-yet-written request is lost.
- No internal buffering beyond the 1-stage output register; throughput is 1 write per cycle.

Test Plan:
- Reset release: rst=1 for 2 cycles, then 0, no requests.
  - Required: rf_we=1 with rf_wa=0..11 and rf_wd=0 on cycles 1..12.
  - busy drops in cycle 12, and readies assert from cycle 12.
- Single ALU write: alu_valid=1, alu_addr=5, alu_data=24'hABCDEF in RUN.
  - Required: alu_ready=1 that cycle.
  - Next cycle: rf_we=1, rf_wa=5, rf_wd=24'hABCDEF; the cycle after: rf_we=0.
- Dual contention: both valid for 4 cycles, prio=ALU.
  - alu_addr=1, data=24'h000111; mem_addr=2, data=24'h000222.
  - Required grant order ALU, MEM, ALU, MEM, giving rf_wa 1, 2, 1, 2 on consecutive cycles.
- Illegal address: mem_valid=1, mem_addr=12.
  - Required: mem_ready=1; next cycle err_addr=1 and rf_we=0.
  - prio=ALU afterwards: with both valid next cycle, ALU is granted.
- Clear request in RUN: pulse clr_req with alu_valid=1.
  - Required: alu_ready=0 that cycle, busy=1 next cycle, 12 zero writes to addresses 0..11.
  - The ALU write completes after the sweep.
- Reset mid-sweep: assert rst while rf_wa=6 during CLEAR.
  - Required: next cycle rf_we=0.
  - After release, the sweep restarts at rf_wa=0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Write-port owner for the 12 x 24-bit register file: round-robin arbitration
// between ALU and memory writeback, plus a zeroing sweep after reset or on request.
module rf_write_arbiter #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              busy,
  output logic              err_addr
);

  typedef enum logic {CLEAR, RUN} state_t;
  typedef enum logic {PRIO_ALU, PRIO_MEM} prio_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NREGS_EXT = (ADDR_W + 1)'(NUM_REGS);

  state_t            state_q, state_d;
  prio_t             prio_q, prio_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;
    err_d     = 1'b0;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    xfer      = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;

    case (state_q)
      CLEAR: begin
        we_d = 1'b1;
        wa_d = cnt_q;
        wd_d = '0;
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_d = CLEAR;
        end else begin
          alu_ready = !mem_valid || (prio_q == PRIO_ALU);
          mem_ready = !alu_valid || (prio_q == PRIO_MEM);
          // Ready equations guarantee at most one of these grants fires.
          if (alu_valid && alu_ready) begin
            xfer     = 1'b1;
            sel_addr = alu_addr;
            sel_data = alu_data;
            prio_d   = PRIO_MEM;
          end else if (mem_valid && mem_ready) begin
            xfer     = 1'b1;
            sel_addr = mem_addr;
            sel_data = mem_data;
            prio_d   = PRIO_ALU;
          end
        end
      end
      default: state_d = CLEAR;
    endcase

    // Illegal destinations are consumed but only flagged, never written.
    if (xfer) begin
      if ({1'b0, sel_addr} < NREGS_EXT) begin
        we_d = 1'b1;
        wa_d = sel_addr;
        wd_d = sel_data;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      prio_q  <= PRIO_ALU;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_wa    = wa_q;
  assign rf_wd    = wd_q;
  assign err_addr = err_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: stimulus pushes expected write-port
// events (with the cycle they must appear in); a monitor pops and compares.
module tb_rf_write_arbiter;

  localparam int unsigned DW = 24;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr_req = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] alu_data = '0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_data = '0;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic          busy;
  logic          err_addr;

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(12)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .busy(busy), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic          we;
    logic          err;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input logic we, input logic err,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    exp_t e;
    e.cyc = c; e.we = we; e.err = err; e.wa = wa; e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic sweep_expect(input int start, input int last);
    for (int i = 0; i <= last; i++) push(start + i, 1'b1, 1'b0, AW'(i), '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1 || err_addr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: we=%0b err=%0b wa=%0d wd=0x%0h, expected none (cycle %0d)",
                 rf_we, err_addr, rf_wa, rf_wd, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_cycle", 32'(cyc), 32'(e.cyc));
        chk("mon_we", 32'(rf_we), 32'(e.we));
        chk("mon_err", 32'(err_addr), 32'(e.err));
        chk("mon_wa", 32'(rf_wa), 32'(e.wa));
        chk("mon_wd", 32'(rf_wd), 32'(e.wd));
      end
    end
  end

  int start;

  initial begin
    // Reset release and initial sweep
    tick(); tick();
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_wa", 32'(rf_wa), 0);
    chk("rst_wd", 32'(rf_wd), 0);
    chk("rst_err", 32'(err_addr), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_alu_ready", 32'(alu_ready), 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    rst = 1'b0;
    start = cyc + 1;
    sweep_expect(start, 11);
    repeat (11) tick();
    chk("sweep_busy_c11", 32'(busy), 1);
    chk("sweep_ready_c11", 32'(alu_ready), 0);
    tick();
    chk("sweep_busy_c12", 32'(busy), 0);
    chk("run_alu_ready", 32'(alu_ready), 1);
    chk("run_mem_ready", 32'(mem_ready), 1);

    // Single ALU write (prio becomes MEM)
    alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 24'hABCDEF;
    #1;
    chk("alu_single_ready", 32'(alu_ready), 1);
    push(cyc + 1, 1'b1, 1'b0, 4'd5, 24'hABCDEF);
    tick();
    alu_valid = 1'b0;
    tick();
    chk("alu_single_we_after", 32'(rf_we), 0);

    // Single MEM write restores prio to ALU
    mem_valid = 1'b1; mem_addr = 4'd3; mem_data = 24'h000333;
    #1;
    chk("mem_single_ready", 32'(mem_ready), 1);
    push(cyc + 1, 1'b1, 1'b0, 4'd3, 24'h000333);
    tick();
    mem_valid = 1'b0;

    // Dual contention: ALU, MEM, ALU, MEM
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 24'h000111;
    mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 24'h000222;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dual_alu_ready", 32'(alu_ready), (i % 2 == 0) ? 1 : 0);
      chk("dual_mem_ready", 32'(mem_ready), (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 0) push(cyc + 1, 1'b1, 1'b0, 4'd1, 24'h000111);
      else            push(cyc + 1, 1'b1, 1'b0, 4'd2, 24'h000222);
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // Illegal address from MEM: accepted, flagged, port holds last write
    mem_valid = 1'b1; mem_addr = 4'd12; mem_data = 24'hDEAD00;
    #1;
    chk("illegal_mem_ready", 32'(mem_ready), 1);
    push(cyc + 1, 1'b0, 1'b1, 4'd2, 24'h000222);
    tick();
    alu_valid = 1'b1; alu_addr = 4'd4; alu_data = 24'h000444;
    mem_addr  = 4'd7; mem_data = 24'h000777;
    #1;
    chk("post_illegal_alu_ready", 32'(alu_ready), 1);
    chk("post_illegal_mem_ready", 32'(mem_ready), 0);
    push(cyc + 1, 1'b1, 1'b0, 4'd4, 24'h000444);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("post_illegal_mem_ready2", 32'(mem_ready), 1);
    push(cyc + 1, 1'b1, 1'b0, 4'd7, 24'h000777);
    tick();
    mem_valid = 1'b0;

    // Clear request in RUN with a pending ALU write
    clr_req = 1'b1; alu_valid = 1'b1; alu_addr = 4'd9; alu_data = 24'h000999;
    #1;
    chk("clr_alu_ready", 32'(alu_ready), 0);
    chk("clr_mem_ready", 32'(mem_ready), 0);
    tick();
    clr_req = 1'b0;
    chk("clr_busy", 32'(busy), 1);
    chk("clr_alu_ready_sweep", 32'(alu_ready), 0);
    start = cyc + 1;
    sweep_expect(start, 11);
    push(start + 12, 1'b1, 1'b0, 4'd9, 24'h000999);
    repeat (12) tick();
    chk("clr_alu_ready_after", 32'(alu_ready), 1);
    tick();
    alu_valid = 1'b0;
    tick();

    // Reset mid-sweep at rf_wa = 6
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    start = cyc + 1;
    sweep_expect(start, 6);
    repeat (7) tick();
    chk("midsweep_wa_before_rst", 32'(rf_wa), 6);
    rst = 1'b1;
    tick();
    chk("midsweep_rst_we", 32'(rf_we), 0);
    chk("midsweep_rst_wa", 32'(rf_wa), 0);
    chk("midsweep_rst_busy", 32'(busy), 1);
    rst = 1'b0;
    start = cyc + 1;
    sweep_expect(start, 11);
    repeat (14) tick();
    chk("final_busy", 32'(busy), 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
